video_stream_checker: RTL and testbench
=======================================

Name: video_stream_checker

Overview:
- Synthesizable, parametrised stream comparator for the VGA pixel pipeline.
- Buffers a golden (expected) pixel stream in a latency-absorbing FIFO and compares it with the DUT output stream pixel by pixel.
- Compares with a per-channel mask and an LSB tolerance.
- Reports mismatch/pixel/frame counts, the coordinate of the first mismatch, and a per-frame pass flag.
- Sits beside the DUT in on-chip regression builds, replacing file-based offline comparison.

Parameters:
- NCH, 3, number of colour channels per pixel
- DW, 8, bits per channel
- HRES, 1600, active pixels per line
- VRES, 900, active lines per frame
- CW, 11, width of the column/row coordinate counters
- DEPTH, 16, expected-pixel FIFO depth (power of 2); must be at least the maximum DUT latency in pixels
- TOL_SHIFT, 1, number of LSBs ignored per channel in the compare
- ERRW, 32, width of the mismatch/pixel/frame counters

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- enable  in  1  arm the checker
- clear  in  1  synchronous clear of counters, flags, FIFO and FSM
- cont  in  1  1: check frames continuously; 0: check one frame, then go idle
- ch_mask  in  NCH  per-channel compare enable
- exp_dv, exp_vs  in  1 each  golden stream data-valid and vsync
- exp_data  in  NCH*DW  golden pixel, channel 0 in the LSBs
- dut_dv, dut_vs  in  1 each  DUT stream data-valid and vsync
- dut_data  in  NCH*DW  DUT pixel
- err_pulse  out  1  one-cycle pulse on each mismatching pixel
- mismatch_cnt  out  ERRW  mismatching pixels since clear
- pixel_cnt  out  ERRW  compared pixels since clear
- frame_cnt  out  ERRW  completed frames since clear
- first_valid  out  1  first_col/first_row hold a valid capture
- first_col, first_row  out  CW each  coordinate of the first mismatch since clear
- frame_done  out  1  one-cycle pulse at the end of each frame
- frame_pass  out  1  result of the last completed frame
- ovf_sticky, udf_sticky  out  1 each  FIFO overflow / underflow seen
- busy  out  1  FSM is not in IDLE

Behaviour:
- Reset (rst=0, asynchronous): every output 0, FIFO empty, FSM in IDLE, coordinate counters 0.
- clear=1: same state as reset, applied at the clock edge; clear has priority over all other activity.
- FSM states: IDLE, SYNC, RUN, DONE.
  - IDLE -> SYNC when enable=1.
  - SYNC: flush the FIFO and wait for rising edges of both exp_vs and dut_vs. They may occur in the same cycle or in different cycles; each is latched as seen.
  - SYNC -> RUN on the cycle after both edges have been seen.
  - RUN -> DONE after the compare of pixel (HRES-1, VRES-1).
  - DONE lasts one cycle: frame_done=1, frame_pass latched, frame_cnt++.
  - DONE -> SYNC if cont=1 and enable=1; otherwise DONE -> IDLE.
  - enable=0 in any state -> IDLE at the next edge; counters and flags are kept.
- FIFO push (RUN only): exp_data is pushed on exp_dv.
  - Push while full and no pop in the same cycle: push dropped, ovf_sticky=1.
  - Simultaneous push and pop while full: legal.
- Compare (RUN only): on dut_dv, pop the FIFO head and compare.
  - Channel c mismatches when ch_mask[c]=1 and (dut_c >> TOL_SHIFT) != (exp_c >> TOL_SHIFT).
  - Pixel mismatch = OR over all channels.
  - dut_dv with the FIFO empty: udf_sticky=1 and the pixel counts as a mismatch.
- Latency: err_pulse, counter updates and first-mismatch capture are registered, 1 cycle after the dut_dv cycle.
- Coordinates follow the DUT stream.
  - col increments per dut_dv; at HRES-1 col wraps to 0 and row increments.
  - row wraps at VRES-1.
  - Both reset to 0 on entry to RUN.
- First capture: on the first mismatch after clear, latch col/row and set first_valid. Later mismatches do not overwrite it.
- Counters saturate at all-ones and never wrap.
- frame_pass=1 only if the frame had no mismatch, no underflow and no overflow.

Decomposition:
- Package vid_chk_pkg:
  - chk_state_t enum {IDLE, SYNC, RUN, DONE}
  - pixel_t packed array [NCH][DW]
  - coordinate typedef coord_t of width CW
- Sub-module vid_chk_fifo: synchronous FIFO, parameters DEPTH and width NCH*DW.
  - Ports: push, pop, din, dout, full, empty, flush.
  - Reads are first-word-fall-through.

Test Plan (HRES=4, VRES=2, DEPTH=4, TOL_SHIFT=1, NCH=3, DW=8 unless stated):
1. Identical streams, DUT delayed 3 pixels, cont=0 -> pixel_cnt=8, mismatch_cnt=0, one frame_done pulse, frame_pass=1, FSM back in IDLE.
2. DUT red 0x41 vs expected 0x40 at (1,0); DUT red 0x42 vs expected 0x40 at (2,1) -> mismatch_cnt=1, first_col=2, first_row=1, exactly one err_pulse, frame_pass=0.
3. ch_mask=3'b011 with blue differing on every pixel -> mismatch_cnt=0, frame_pass=1.
4. DUT delayed 6 pixels with DEPTH=4 -> ovf_sticky=1, frame_pass=0.
5. dut_dv asserted before any exp_dv in RUN -> udf_sticky=1, mismatch_cnt=1.
6. Second case: cont=1 over 2 clean frames -> frame_cnt=2; then rst low mid-line -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/vid_chk_pkg.sv
// rtl/vid_chk_pkg.sv - shared types for the video stream checker
package vid_chk_pkg;

    localparam int PKG_NCH = 3;
    localparam int PKG_DW  = 8;
    localparam int PKG_CW  = 11;

    typedef enum logic [1:0] {IDLE, SYNC, RUN, DONE} chk_state_t;

    typedef logic [PKG_NCH-1:0][PKG_DW-1:0] pixel_t;
    typedef logic [PKG_CW-1:0]              coord_t;

endpackage

// File: rtl/vid_chk_fifo.sv
// rtl/vid_chk_fifo.sv - first-word-fall-through FIFO holding expected pixels
module vid_chk_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/video_stream_checker.sv
// rtl/video_stream_checker.sv - compares a DUT pixel stream against a buffered golden stream
module video_stream_checker
    import vid_chk_pkg::*;
#(
    parameter int NCH       = 3,
    parameter int DW        = 8,
    parameter int HRES      = 1600,
    parameter int VRES      = 900,
    parameter int CW        = 11,
    parameter int DEPTH     = 16,
    parameter int TOL_SHIFT = 1,
    parameter int ERRW      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              cont,
    input  logic [NCH-1:0]    ch_mask,
    input  logic              exp_dv,
    input  logic              exp_vs,
    input  logic [NCH*DW-1:0] exp_data,
    input  logic              dut_dv,
    input  logic              dut_vs,
    input  logic [NCH*DW-1:0] dut_data,
    output logic              err_pulse,
    output logic [ERRW-1:0]   mismatch_cnt,
    output logic [ERRW-1:0]   pixel_cnt,
    output logic [ERRW-1:0]   frame_cnt,
    output logic              first_valid,
    output logic [CW-1:0]     first_col,
    output logic [CW-1:0]     first_row,
    output logic              frame_done,
    output logic              frame_pass,
    output logic              ovf_sticky,
    output logic              udf_sticky,
    output logic              busy
);

    localparam int W = NCH * DW;
    localparam logic [CW-1:0] COL_LAST = CW'(HRES - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(VRES - 1);

    chk_state_t     state;
    chk_state_t     state_nxt;
    logic           exp_vs_q;
    logic           dut_vs_q;
    logic           exp_seen;
    logic           dut_seen;
    logic [CW-1:0]  col;
    logic [CW-1:0]  row;
    logic           frame_err;

    logic           exp_rise;
    logic           dut_rise;
    logic           run;
    logic           cmp_fire;
    logic           px_bad;
    logic           ovf_now;
    logic           last_px;
    logic [NCH-1:0] ch_bad;

    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_flush;
    logic           fifo_full;
    logic           fifo_empty;
    logic [W-1:0]   fifo_dout;

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign exp_rise   = exp_vs & ~exp_vs_q;
    assign dut_rise   = dut_vs & ~dut_vs_q;
    assign run        = (state == RUN);
    assign fifo_push  = run & exp_dv;
    assign fifo_pop   = run & dut_dv & ~fifo_empty;
    assign fifo_flush = clear | (state == SYNC);
    assign ovf_now    = fifo_push & fifo_full & ~fifo_pop;
    assign cmp_fire   = run & dut_dv;
    assign last_px    = (col == COL_LAST) && (row == ROW_LAST);
    assign frame_done = (state == DONE);
    assign busy       = (state != IDLE);

    vid_chk_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (exp_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The low TOL_SHIFT bits of each channel are dropped before comparing.
    always_comb begin
        ch_bad = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_bad[c] = ch_mask[c] &&
                ((dut_data[c*DW +: DW] >> TOL_SHIFT) != (fifo_dout[c*DW +: DW] >> TOL_SHIFT));
        end
    end

    assign px_bad = fifo_empty | (|ch_bad);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = SYNC;
            SYNC: if ((exp_seen | exp_rise) && (dut_seen | dut_rise)) state_nxt = RUN;
            RUN:  if (dut_dv && last_px) state_nxt = DONE;
            DONE: state_nxt = (cont && enable) ? SYNC : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!enable) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            exp_vs_q     <= 1'b0;
            dut_vs_q     <= 1'b0;
            exp_seen     <= 1'b0;
            dut_seen     <= 1'b0;
            col          <= '0;
            row          <= '0;
            frame_err    <= 1'b0;
            err_pulse    <= 1'b0;
            mismatch_cnt <= '0;
            pixel_cnt    <= '0;
            frame_cnt    <= '0;
            first_valid  <= 1'b0;
            first_col    <= '0;
            first_row    <= '0;
            frame_pass   <= 1'b0;
            ovf_sticky   <= 1'b0;
            udf_sticky   <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            exp_vs_q     <= 1'b0;
            dut_vs_q     <= 1'b0;
            exp_seen     <= 1'b0;
            dut_seen     <= 1'b0;
            col          <= '0;
            row          <= '0;
            frame_err    <= 1'b0;
            err_pulse    <= 1'b0;
            mismatch_cnt <= '0;
            pixel_cnt    <= '0;
            frame_cnt    <= '0;
            first_valid  <= 1'b0;
            first_col    <= '0;
            first_row    <= '0;
            frame_pass   <= 1'b0;
            ovf_sticky   <= 1'b0;
            udf_sticky   <= 1'b0;
        end else begin
            state     <= state_nxt;
            exp_vs_q  <= exp_vs;
            dut_vs_q  <= dut_vs;
            exp_seen  <= (state == SYNC) & (exp_seen | exp_rise);
            dut_seen  <= (state == SYNC) & (dut_seen | dut_rise);
            err_pulse <= cmp_fire & px_bad;

            // Coordinates track the DUT stream and restart on every RUN entry.
            if (!run) begin
                col <= '0;
                row <= '0;
            end else if (dut_dv) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (state == SYNC) begin
                frame_err <= 1'b0;
            end else if ((cmp_fire && px_bad) || ovf_now) begin
                frame_err <= 1'b1;
            end

            if (cmp_fire) pixel_cnt <= sat_inc(pixel_cnt);

            if (cmp_fire && px_bad) begin
                mismatch_cnt <= sat_inc(mismatch_cnt);
                if (!first_valid) begin
                    first_valid <= 1'b1;
                    first_col   <= col;
                    first_row   <= row;
                end
            end

            if (ovf_now)                  ovf_sticky <= 1'b1;
            if (cmp_fire && fifo_empty)   udf_sticky <= 1'b1;

            if (state == DONE) begin
                frame_pass <= ~frame_err;
                frame_cnt  <= sat_inc(frame_cnt);
            end
        end
    end

endmodule

// File: tb/tb_video_stream_checker.sv
// tb/tb_video_stream_checker.sv - scoreboard bench for video_stream_checker
module tb_video_stream_checker;

    localparam int NCH       = 3;
    localparam int DW        = 8;
    localparam int HRES      = 4;
    localparam int VRES      = 2;
    localparam int CW        = 11;
    localparam int DEPTH     = 4;
    localparam int TOL_SHIFT = 1;
    localparam int ERRW      = 32;
    localparam int NPX       = HRES * VRES;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              clear;
    logic              cont;
    logic [NCH-1:0]    ch_mask;
    logic              exp_dv;
    logic              exp_vs;
    logic [NCH*DW-1:0] exp_data;
    logic              dut_dv;
    logic              dut_vs;
    logic [NCH*DW-1:0] dut_data;
    logic              err_pulse;
    logic [ERRW-1:0]   mismatch_cnt;
    logic [ERRW-1:0]   pixel_cnt;
    logic [ERRW-1:0]   frame_cnt;
    logic              first_valid;
    logic [CW-1:0]     first_col;
    logic [CW-1:0]     first_row;
    logic              frame_done;
    logic              frame_pass;
    logic              ovf_sticky;
    logic              udf_sticky;
    logic              busy;

    typedef struct {
        bit pass;
        int mism;
        int pix;
        int frames;
        bit ovf;
        bit udf;
        bit fv;
        int fcol;
        int frow;
        int pulses;
        bit busy;
    } frame_exp_t;

    frame_exp_t        exp_q[$];
    int                n_chk  = 0;
    int                n_fail = 0;
    int                pulses = 0;
    logic [NCH*DW-1:0] exp_px [NPX];
    logic [NCH*DW-1:0] dut_px [NPX];

    video_stream_checker #(
        .NCH       (NCH),
        .DW        (DW),
        .HRES      (HRES),
        .VRES      (VRES),
        .CW        (CW),
        .DEPTH     (DEPTH),
        .TOL_SHIFT (TOL_SHIFT),
        .ERRW      (ERRW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .cont         (cont),
        .ch_mask      (ch_mask),
        .exp_dv       (exp_dv),
        .exp_vs       (exp_vs),
        .exp_data     (exp_data),
        .dut_dv       (dut_dv),
        .dut_vs       (dut_vs),
        .dut_data     (dut_data),
        .err_pulse    (err_pulse),
        .mismatch_cnt (mismatch_cnt),
        .pixel_cnt    (pixel_cnt),
        .frame_cnt    (frame_cnt),
        .first_valid  (first_valid),
        .first_col    (first_col),
        .first_row    (first_row),
        .frame_done   (frame_done),
        .frame_pass   (frame_pass),
        .ovf_sticky   (ovf_sticky),
        .udf_sticky   (udf_sticky),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input bit pass, input int mism, input int pix, input int frames,
                                input bit ovf, input bit udf, input bit fv, input int fcol,
                                input int frow, input int npulse, input bit bsy);
        frame_exp_t e;
        e.pass = pass;  e.mism = mism;  e.pix = pix;    e.frames = frames;
        e.ovf = ovf;    e.udf = udf;    e.fv = fv;      e.fcol = fcol;
        e.frow = frow;  e.pulses = npulse;              e.busy = bsy;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_err_pulse"},    err_pulse,    0);
        chk({tag, "_mismatch_cnt"}, mismatch_cnt, 0);
        chk({tag, "_pixel_cnt"},    pixel_cnt,    0);
        chk({tag, "_frame_cnt"},    frame_cnt,    0);
        chk({tag, "_first_valid"},  first_valid,  0);
        chk({tag, "_first_col"},    first_col,    0);
        chk({tag, "_first_row"},    first_row,    0);
        chk({tag, "_frame_done"},   frame_done,   0);
        chk({tag, "_frame_pass"},   frame_pass,   0);
        chk({tag, "_ovf_sticky"},   ovf_sticky,   0);
        chk({tag, "_udf_sticky"},   udf_sticky,   0);
        chk({tag, "_busy"},         busy,         0);
    endtask

    task automatic default_pixels();
        for (int i = 0; i < NPX; i++) begin
            exp_px[i] = {8'(i*4 + 2), 8'(i*8 + 1), 8'(i*16)};
            dut_px[i] = exp_px[i];
        end
    endtask

    task automatic clear_and_arm();
        clear = 1'b1;
        step();
        clear  = 1'b0;
        pulses = 0;
        step();
        step();
    endtask

    // Golden vsync at cycle 1, active pixels from cycle 10; the DUT copy is lat cycles later.
    task automatic run_frame(input int lat, input int extra_dv, input int abort_at);
        for (int c = 0; c < 22 + lat; c++) begin
            if (c == abort_at) return;
            exp_vs = (c >= 1 && c < 3);
            dut_vs = (c >= 1 + lat && c < 3 + lat);
            exp_dv = (c >= 10 && c < 10 + NPX);
            if (c >= 10 && c < 10 + NPX) exp_data = exp_px[c-10];
            else                         exp_data = '0;
            dut_dv = (c >= 10 + lat && c < 10 + lat + NPX) || (c == extra_dv);
            if (c >= 10 + lat && c < 10 + lat + NPX) dut_data = dut_px[c-10-lat];
            else                                     dut_data = '0;
            step();
        end
        exp_vs = 1'b0; dut_vs = 1'b0; exp_dv = 1'b0; dut_dv = 1'b0;
        exp_data = '0; dut_data = '0;
    endtask

    initial begin : monitor
        frame_exp_t e;
        forever begin
            @(negedge clk);
            if (err_pulse === 1'b1) pulses++;
            if (frame_done === 1'b1) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame: actual frame_done pulse required none");
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_pass",   frame_pass,   e.pass);
                    chk("mismatch_cnt", mismatch_cnt, e.mism);
                    chk("pixel_cnt",    pixel_cnt,    e.pix);
                    chk("frame_cnt",    frame_cnt,    e.frames);
                    chk("ovf_sticky",   ovf_sticky,   e.ovf);
                    chk("udf_sticky",   udf_sticky,   e.udf);
                    chk("first_valid",  first_valid,  e.fv);
                    chk("first_col",    first_col,    e.fcol);
                    chk("first_row",    first_row,    e.frow);
                    chk("err_pulses",   pulses,       e.pulses);
                    chk("busy_after",   busy,         e.busy);
                end
                pulses = 0;
            end
        end
    end

    initial begin : stimulus
        rst = 1'b0; enable = 1'b0; clear = 1'b0; cont = 1'b0; ch_mask = 3'b111;
        exp_dv = 1'b0; exp_vs = 1'b0; exp_data = '0;
        dut_dv = 1'b0; dut_vs = 1'b0; dut_data = '0;
        repeat (2) step();
        check_all_zero("reset");
        rst    = 1'b1;
        enable = 1'b1;
        step();

        // Identical streams, DUT three pixels late.
        default_pixels();
        clear_and_arm();
        expect_frame(1, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        run_frame(3, -1, -1);

        // LSB-only difference at (1,0) is tolerated; (2,1) is a real mismatch.
        default_pixels();
        exp_px[1][7:0] = 8'h40; dut_px[1][7:0] = 8'h41;
        exp_px[6][7:0] = 8'h40; dut_px[6][7:0] = 8'h42;
        clear_and_arm();
        expect_frame(0, 1, 8, 1, 0, 0, 1, 2, 1, 1, 0);
        run_frame(3, -1, -1);

        // Blue channel masked off while it differs on every pixel.
        default_pixels();
        for (int i = 0; i < NPX; i++) dut_px[i][23:16] = exp_px[i][23:16] ^ 8'h80;
        ch_mask = 3'b011;
        clear_and_arm();
        expect_frame(1, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        run_frame(3, -1, -1);
        ch_mask = 3'b111;

        // Six pixels of latency overruns the four-deep FIFO.
        default_pixels();
        clear_and_arm();
        expect_frame(0, 4, 8, 1, 1, 1, 1, 0, 1, 4, 0);
        run_frame(6, -1, -1);

        // A lone DUT pixel before any golden pixel arrives.
        default_pixels();
        clear_and_arm();
        expect_frame(0, 1, 8, 1, 0, 1, 1, 0, 0, 1, 0);
        run_frame(3, 7, -1);

        // Continuous mode over two clean frames, then async reset mid-line.
        default_pixels();
        cont = 1'b1;
        clear_and_arm();
        expect_frame(1, 0, 8,  1, 0, 0, 0, 0, 0, 0, 1);
        expect_frame(1, 0, 16, 2, 0, 0, 0, 0, 0, 0, 1);
        run_frame(3, -1, -1);
        run_frame(3, -1, -1);
        run_frame(3, -1, 15);
        chk("pixel_cnt_before_reset", pixel_cnt, 18);
        chk("frame_cnt_before_reset", frame_cnt, 2);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        step();
        rst = 1'b1;
        step();

        chk("pending_frames", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
